// File: rtl/alarm_pkg.sv
// Shared types and widths for the alarm scheduler.
package alarm_pkg;
   localparam int unsigned HRS_W   = 5;
   localparam int unsigned MIN_W   = 6;
   localparam int unsigned HOURS   = 24;
   localparam int unsigned MINUTES = 60;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      RINGING = 2'd1,
      SNOOZE  = 2'd2
   } alarm_state_t;
endpackage

// File: rtl/wake_calc.sv
// Combinational snooze wake-time: current time plus SNOOZE_MIN minutes, wrapping mod 60 / mod 24.
module wake_calc
   import alarm_pkg::*;
#(
   parameter int unsigned SNOOZE_MIN = 9
) (
   input  logic [HRS_W-1:0] Hrs,
   input  logic [MIN_W-1:0] Mins,
   output logic [HRS_W-1:0] WHrs,
   output logic [MIN_W-1:0] WMins
);
   logic [MIN_W:0] sum;

   always_comb begin
      sum   = {1'b0, Mins} + (MIN_W+1)'(SNOOZE_MIN);
      WHrs  = Hrs;
      WMins = sum[MIN_W-1:0];
      if (sum >= (MIN_W+1)'(MINUTES)) begin
         WMins = MIN_W'(sum - (MIN_W+1)'(MINUTES));
         WHrs  = (Hrs == HRS_W'(HOURS-1)) ? '0 : Hrs + HRS_W'(1);
      end
   end
endmodule

// File: rtl/alarm_ctrl.sv
// Alarm scheduler: alarm-time registers, ring/snooze/auto-off sequencing and user cancel.
module alarm_ctrl
   import alarm_pkg::*;
#(
   parameter int unsigned SNOOZE_MIN = 9,
   parameter int unsigned RING_SECS  = 60
) (
   input  logic             Clk,
   input  logic             Reset,
   input  logic             Tick,
   input  logic [HRS_W-1:0] Hrs,
   input  logic [MIN_W-1:0] Mins,
   input  logic [MIN_W-1:0] Secs,
   input  logic             Alarmset,
   input  logic             Hrsadv,
   input  logic             Minadv,
   input  logic             Alarmon,
   input  logic             Snooze,
   output logic [HRS_W-1:0] AHrs,
   output logic [MIN_W-1:0] AMins,
   output logic             Buzz,
   output logic             Snoozing
);
   localparam int unsigned RC_W = (RING_SECS > 1) ? $clog2(RING_SECS) : 1;

   alarm_state_t     state, next_state;
   logic [HRS_W-1:0] WHrs, calc_hrs, tgt_hrs;
   logic [MIN_W-1:0] WMins, calc_mins, tgt_mins;
   logic [RC_W-1:0]  ring_cnt;
   logic             match, match_q, snooze_q;
   logic             trigger, snooze_ev, cancel, ring_done;

   wake_calc #(.SNOOZE_MIN(SNOOZE_MIN)) u_wake_calc (
      .Hrs   (Hrs),
      .Mins  (Mins),
      .WHrs  (calc_hrs),
      .WMins (calc_mins)
   );

   // Compare against the wake time only while snoozing.
   always_comb begin
      tgt_hrs   = (state == SNOOZE) ? WHrs  : AHrs;
      tgt_mins  = (state == SNOOZE) ? WMins : AMins;
      match     = (Hrs == tgt_hrs) && (Mins == tgt_mins) && (Secs == '0);
      trigger   = match && !match_q;
      snooze_ev = Snooze && !snooze_q;
      cancel    = !Alarmon || Alarmset;
      ring_done = Tick && (ring_cnt == RC_W'(RING_SECS-1));
   end

   always_comb begin
      next_state = state;
      case (state)
         IDLE:    if (trigger) next_state = RINGING;
         RINGING: begin
            if (snooze_ev)      next_state = SNOOZE;
            else if (ring_done) next_state = IDLE;
         end
         SNOOZE:  if (trigger) next_state = RINGING;
         default: next_state = IDLE;
      endcase
      if (cancel) next_state = IDLE;
   end

   always_ff @(posedge Clk) begin
      if (Reset) state <= IDLE;
      else       state <= next_state;
   end

   // match_q resets high so a 00:00:00 time at reset exit does not ring.
   always_ff @(posedge Clk) begin
      if (Reset) begin
         AHrs     <= '0;
         AMins    <= '0;
         WHrs     <= '0;
         WMins    <= '0;
         Buzz     <= 1'b0;
         Snoozing <= 1'b0;
         ring_cnt <= '0;
         snooze_q <= 1'b0;
         match_q  <= 1'b1;
      end else begin
         match_q  <= match;
         snooze_q <= Snooze;
         Buzz     <= (next_state == RINGING);
         Snoozing <= (next_state == SNOOZE);
         if (Alarmset) begin
            if (Hrsadv) AHrs  <= (AHrs  == HRS_W'(HOURS-1))   ? '0 : AHrs  + HRS_W'(1);
            if (Minadv) AMins <= (AMins == MIN_W'(MINUTES-1)) ? '0 : AMins + MIN_W'(1);
         end
         if (state == RINGING && next_state == SNOOZE) begin
            WHrs  <= calc_hrs;
            WMins <= calc_mins;
         end
         if (state != RINGING && next_state == RINGING) ring_cnt <= '0;
         else if (state == RINGING && Tick)             ring_cnt <= ring_cnt + RC_W'(1);
      end
   end
endmodule
